// File: rtl/lfsr_multistep_if.sv
// Handshake/data bundle between the pattern logic and the multi-step LFSR.
// master drives enable/seed, slave (the LFSR) returns state and status.
interface lfsr_multistep_if #(
    parameter int NUM_BITS = 4
);
    logic                i_Enable;
    logic                i_Seed_DV;
    logic [NUM_BITS-1:0] i_Seed_Data;
    logic [NUM_BITS-1:0] o_LFSR_Data;
    logic                o_LFSR_Bit;
    logic                o_LFSR_Done;
    logic                o_Seed_Err;
    logic [NUM_BITS-1:0] o_Period;

    modport master (
        output i_Enable, i_Seed_DV, i_Seed_Data,
        input  o_LFSR_Data, o_LFSR_Bit, o_LFSR_Done, o_Seed_Err, o_Period
    );

    modport slave (
        input  i_Enable, i_Seed_DV, i_Seed_Data,
        output o_LFSR_Data, o_LFSR_Bit, o_LFSR_Done, o_Seed_Err, o_Period
    );
endinterface

// File: rtl/lfsr_multistep.sv
// Maximal-length XNOR Fibonacci LFSR (3..32 bits) advancing STEPS_PER_CLK shifts
// per enable, with lockup-seed rejection, period-complete pulse and period measurement.
module lfsr_multistep #(
    parameter int                  NUM_BITS      = 4,
    parameter int                  STEPS_PER_CLK = 1,
    parameter logic [NUM_BITS-1:0] RESET_SEED    = {1'b1, {(NUM_BITS-1){1'b0}}}
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    lfsr_multistep_if.slave  bus
);

    function automatic logic [31:0] t(input int k);
        return 32'd1 << (k - 1);
    endfunction

    // XNOR tap sets; tap k is state bit k-1
    function automatic logic [31:0] tap_mask(input int n);
        logic [31:0] m;
        m = '0;
        case (n)
            3:  m = t(3)  | t(2);
            4:  m = t(4)  | t(3);
            5:  m = t(5)  | t(3);
            6:  m = t(6)  | t(5);
            7:  m = t(7)  | t(6);
            8:  m = t(8)  | t(6)  | t(5)  | t(4);
            9:  m = t(9)  | t(5);
            10: m = t(10) | t(7);
            11: m = t(11) | t(9);
            12: m = t(12) | t(6)  | t(4)  | t(1);
            13: m = t(13) | t(4)  | t(3)  | t(1);
            14: m = t(14) | t(5)  | t(3)  | t(1);
            15: m = t(15) | t(14);
            16: m = t(16) | t(15) | t(13) | t(4);
            17: m = t(17) | t(14);
            18: m = t(18) | t(11);
            19: m = t(19) | t(6)  | t(2)  | t(1);
            20: m = t(20) | t(17);
            21: m = t(21) | t(19);
            22: m = t(22) | t(21);
            23: m = t(23) | t(18);
            24: m = t(24) | t(23) | t(22) | t(17);
            25: m = t(25) | t(22);
            26: m = t(26) | t(6)  | t(2)  | t(1);
            27: m = t(27) | t(5)  | t(2)  | t(1);
            28: m = t(28) | t(25);
            29: m = t(29) | t(27);
            30: m = t(30) | t(6)  | t(4)  | t(1);
            31: m = t(31) | t(28);
            32: m = t(32) | t(22) | t(2)  | t(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [31:0]         TAP_ALL  = tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAPS     = TAP_ALL[NUM_BITS-1:0];
    localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

    generate
        if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
            $error("lfsr_multistep: NUM_BITS must be 3..32");
        end
        if (STEPS_PER_CLK < 1 || STEPS_PER_CLK > 8) begin : g_bad_steps
            $error("lfsr_multistep: STEPS_PER_CLK must be 1..8");
        end
        if (RESET_SEED == ALL_ONES) begin : g_bad_seed
            $error("lfsr_multistep: RESET_SEED must not be the lockup state");
        end
    endgenerate

    logic [NUM_BITS-1:0] data_reg;
    logic [NUM_BITS-1:0] ref_reg;
    logic [NUM_BITS-1:0] cnt_reg;
    logic [NUM_BITS-1:0] period_reg;
    logic                done_reg;
    logic                err_reg;
    logic [NUM_BITS-1:0] data_next;
    logic [NUM_BITS-1:0] cnt_next;

    // Sub-steps chained combinationally; only the last one is compared to the seed
    genvar gi;
    generate
        for (gi = 0; gi < STEPS_PER_CLK; gi++) begin : g_step
            logic [NUM_BITS-1:0] cur;
            logic [NUM_BITS-1:0] nxt;
            if (gi == 0) begin : g_first
                assign cur = data_reg;
            end else begin : g_chain
                assign cur = g_step[gi-1].nxt;
            end
            assign nxt = {cur[NUM_BITS-2:0], ~^(cur & TAPS)};
        end
    endgenerate

    assign data_next = g_step[STEPS_PER_CLK-1].nxt;
    assign cnt_next  = (cnt_reg == ALL_ONES) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            data_reg   <= RESET_SEED;
            ref_reg    <= RESET_SEED;
            cnt_reg    <= '0;
            period_reg <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (bus.i_Seed_DV) begin
                cnt_reg <= '0;
                if (bus.i_Seed_Data == ALL_ONES) begin
                    data_reg <= RESET_SEED;
                    ref_reg  <= RESET_SEED;
                    err_reg  <= 1'b1;
                end else begin
                    data_reg <= bus.i_Seed_Data;
                    ref_reg  <= bus.i_Seed_Data;
                end
            end else if (bus.i_Enable) begin
                data_reg <= data_next;
                if (data_next == ref_reg) begin
                    done_reg   <= 1'b1;
                    period_reg <= cnt_next;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    end

    assign bus.o_LFSR_Data = data_reg;
    assign bus.o_LFSR_Bit  = data_reg[NUM_BITS-1];
    assign bus.o_LFSR_Done = done_reg;
    assign bus.o_Seed_Err  = err_reg;
    assign bus.o_Period    = period_reg;

endmodule

// File: tb/tb_lfsr_multistep.sv
// Directed bench for lfsr_multistep: 4-bit sequences at 1/2/3 steps, seeding,
// gated enables, async reset, and 8/16/32-bit period sweeps.
module tb_lfsr_multistep;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lfsr_multistep_if #(.NUM_BITS(4))  if4a ();
    lfsr_multistep_if #(.NUM_BITS(4))  if4b ();
    lfsr_multistep_if #(.NUM_BITS(4))  if4c ();
    lfsr_multistep_if #(.NUM_BITS(8))  if8  ();
    lfsr_multistep_if #(.NUM_BITS(16)) if16 ();
    lfsr_multistep_if #(.NUM_BITS(32)) if32 ();

    lfsr_multistep #(.NUM_BITS(4),  .STEPS_PER_CLK(1)) u4a (.i_Clk(clk), .i_Rst(rst), .bus(if4a.slave));
    lfsr_multistep #(.NUM_BITS(4),  .STEPS_PER_CLK(2)) u4b (.i_Clk(clk), .i_Rst(rst), .bus(if4b.slave));
    lfsr_multistep #(.NUM_BITS(4),  .STEPS_PER_CLK(3)) u4c (.i_Clk(clk), .i_Rst(rst), .bus(if4c.slave));
    lfsr_multistep #(.NUM_BITS(8),  .STEPS_PER_CLK(1)) u8  (.i_Clk(clk), .i_Rst(rst), .bus(if8.slave));
    lfsr_multistep #(.NUM_BITS(16), .STEPS_PER_CLK(1)) u16 (.i_Clk(clk), .i_Rst(rst), .bus(if16.slave));
    lfsr_multistep #(.NUM_BITS(32), .STEPS_PER_CLK(1)) u32 (.i_Clk(clk), .i_Rst(rst), .bus(if32.slave));

    // Hand-derived 4-bit sequence from 1000 (taps 4,3 XNOR)
    logic [3:0] seq4 [15] = '{4'h8, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                              4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4};
    logic [39:0] en_pattern = 40'hB5_6D_3A_F7_9C;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  idx;
        int  ens;
        int  d8_cnt, d16_cnt, first8;
        bit  ones8, ones16, ones32, rep32;
        logic [3:0] e;

        rst = 1'b1;
        if4a.i_Enable = 0; if4a.i_Seed_DV = 0; if4a.i_Seed_Data = '0;
        if4b.i_Enable = 0; if4b.i_Seed_DV = 0; if4b.i_Seed_Data = '0;
        if4c.i_Enable = 0; if4c.i_Seed_DV = 0; if4c.i_Seed_Data = '0;
        if8.i_Enable  = 0; if8.i_Seed_DV  = 0; if8.i_Seed_Data  = '0;
        if16.i_Enable = 0; if16.i_Seed_DV = 0; if16.i_Seed_Data = '0;
        if32.i_Enable = 0; if32.i_Seed_DV = 0; if32.i_Seed_Data = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset values
        check_eq("rst_data4",   64'(if4a.o_LFSR_Data), 64'h8);
        check_eq("rst_bit4",    64'(if4a.o_LFSR_Bit),  64'h1);
        check_eq("rst_done4",   64'(if4a.o_LFSR_Done), 64'h0);
        check_eq("rst_err4",    64'(if4a.o_Seed_Err),  64'h0);
        check_eq("rst_period4", 64'(if4a.o_Period),    64'h0);
        check_eq("rst_data8",   64'(if8.o_LFSR_Data),  64'h80);

        // Continuous enable on the three 4-bit variants
        if4a.i_Enable = 1; if4b.i_Enable = 1; if4c.i_Enable = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            e = seq4[k % 15];
            check_eq($sformatf("s1_data_k%0d", k), 64'(if4a.o_LFSR_Data), 64'(e));
            check_eq($sformatf("s1_bit_k%0d", k),  64'(if4a.o_LFSR_Bit),  64'(e[3]));
            check_eq($sformatf("s1_done_k%0d", k), 64'(if4a.o_LFSR_Done), 64'(k == 15));
            e = seq4[(2 * k) % 15];
            check_eq($sformatf("s2_data_k%0d", k), 64'(if4b.o_LFSR_Data), 64'(e));
            check_eq($sformatf("s2_done_k%0d", k), 64'(if4b.o_LFSR_Done), 64'(k == 15));
            e = seq4[(3 * k) % 15];
            check_eq($sformatf("s3_data_k%0d", k), 64'(if4c.o_LFSR_Data), 64'(e));
            check_eq($sformatf("s3_done_k%0d", k), 64'(if4c.o_LFSR_Done), 64'(k % 5 == 0));
            check_eq($sformatf("s3_period_k%0d", k), 64'(if4c.o_Period), (k >= 5) ? 64'd5 : 64'd0);
        end
        check_eq("s1_period", 64'(if4a.o_Period), 64'd15);
        check_eq("s2_period", 64'(if4b.o_Period), 64'd15);
        if4a.i_Enable = 0; if4b.i_Enable = 0; if4c.i_Enable = 0;

        // Lockup seed rejection
        if4a.i_Seed_DV = 1; if4a.i_Seed_Data = 4'hF;
        tick();
        check_eq("lock_err",  64'(if4a.o_Seed_Err),  64'h1);
        check_eq("lock_data", 64'(if4a.o_LFSR_Data), 64'h8);
        check_eq("lock_done", 64'(if4a.o_LFSR_Done), 64'h0);
        if4a.i_Seed_DV = 0;
        tick();
        check_eq("lock_err_clr", 64'(if4a.o_Seed_Err), 64'h0);

        // Seed load wins over enable
        if4a.i_Seed_DV = 1; if4a.i_Seed_Data = 4'h3; if4a.i_Enable = 1;
        tick();
        check_eq("seed_data", 64'(if4a.o_LFSR_Data), 64'h3);
        check_eq("seed_err",  64'(if4a.o_Seed_Err),  64'h0);
        check_eq("seed_done", 64'(if4a.o_LFSR_Done), 64'h0);
        check_eq("seed_period_kept", 64'(if4a.o_Period), 64'd15);
        if4a.i_Seed_DV = 0;
        tick();
        check_eq("seed_next", 64'(if4a.o_LFSR_Data), 64'h7);

        // Gated enables: state holds when idle, Done after 15 enabled cycles
        idx = 4;
        ens = 1;
        for (int k = 0; k < 40; k++) begin
            if4a.i_Enable = en_pattern[39 - k];
            tick();
            if (en_pattern[39 - k]) begin
                ens++;
                idx = (idx + 1) % 15;
            end
            check_eq($sformatf("gate_data_k%0d", k), 64'(if4a.o_LFSR_Data), 64'(seq4[idx]));
            check_eq($sformatf("gate_done_k%0d", k), 64'(if4a.o_LFSR_Done),
                     64'(en_pattern[39 - k] && (ens % 15 == 0)));
        end
        check_eq("gate_period", 64'(if4a.o_Period), 64'd15);

        // Async reset between edges, mid-period
        if4a.i_Enable = 1;
        repeat (6) tick();
        if4a.i_Enable = 0;
        #3 rst = 1'b1;
        #1;
        check_eq("arst_data",   64'(if4a.o_LFSR_Data), 64'h8);
        check_eq("arst_period", 64'(if4a.o_Period),    64'h0);
        check_eq("arst_done",   64'(if4a.o_LFSR_Done), 64'h0);
        #1 rst = 1'b0;

        // Counter restarts from reset: Done exactly 15 enables later
        if4a.i_Enable = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_eq($sformatf("post_done_k%0d", k), 64'(if4a.o_LFSR_Done), 64'(k == 15));
        end
        check_eq("post_period", 64'(if4a.o_Period), 64'd15);
        if4a.i_Enable = 0;
        // Pending Done pulse killed by async reset
        #3 rst = 1'b1;
        #1;
        check_eq("arst_done_pulse", 64'(if4a.o_LFSR_Done), 64'h0);
        check_eq("arst_period2",    64'(if4a.o_Period),    64'h0);
        #1 rst = 1'b0;

        // Wide sweeps
        d8_cnt = 0; d16_cnt = 0; first8 = 0;
        ones8 = 0; ones16 = 0; ones32 = 0; rep32 = 0;
        if8.i_Enable = 1; if16.i_Enable = 1; if32.i_Enable = 1;
        for (int k = 1; k <= 65535; k++) begin
            tick();
            if (k == 1) begin
                check_eq("n8_first",  64'(if8.o_LFSR_Data),  64'h0);
                check_eq("n16_first", 64'(if16.o_LFSR_Data), 64'h0);
                check_eq("n32_first", 64'(if32.o_LFSR_Data), 64'h0);
            end
            if (if8.o_LFSR_Done) begin
                d8_cnt++;
                if (first8 == 0) first8 = k;
            end
            if (if16.o_LFSR_Done) d16_cnt++;
            if (if8.o_LFSR_Data == 8'hFF)          ones8  = 1;
            if (if16.o_LFSR_Data == 16'hFFFF)      ones16 = 1;
            if (if32.o_LFSR_Data == 32'hFFFF_FFFF) ones32 = 1;
            if (if32.o_LFSR_Data == 32'h8000_0000 || if32.o_LFSR_Done) rep32 = 1;
        end
        if8.i_Enable = 0; if16.i_Enable = 0; if32.i_Enable = 0;
        check_eq("n8_period",     64'(if8.o_Period),  64'd255);
        check_eq("n8_first_done", 64'(first8),        64'd255);
        check_eq("n8_done_count", 64'(d8_cnt),        64'd257);
        check_eq("n8_no_lockup",  64'(ones8),         64'd0);
        check_eq("n16_period",    64'(if16.o_Period), 64'd65535);
        check_eq("n16_done_count", 64'(d16_cnt),      64'd1);
        check_eq("n16_no_lockup", 64'(ones16),        64'd0);
        check_eq("n32_no_lockup", 64'(ones32),        64'd0);
        check_eq("n32_no_repeat", 64'(rep32),         64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
